// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   On-chip equivalence self-check. Steps through all 2^N input vectors, one
//   per clock. Each vector is applied to two alternative gate-level
//   implementations of the function pair chosen by mode. The block counts the
//   vectors where the two disagree, keeps the first disagreeing vector, and
//   reports an equivalence verdict when the sweep finishes.
//
//   Optional build macro: STOP_ON_MISMATCH_EN
//     defined   - the sweep ends on the edge that records the first mismatch.
//                 vec is left holding the failing vector and mismatch_cnt is 1.
//                 A pair that never disagrees still sweeps all 2^N vectors.
//     undefined - every sweep covers all 2^N vectors.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         sweep request; only looked at in IDLE or DONE
//   mode[1:0]     function-pair select; captured when a start is accepted
//   busy          high while the sweep is running
//   done          high in DONE until the next accepted start
//   vec[N-1:0]    vector currently applied to both implementations
//   f_a, f_b      implementation A / B result for vec (combinational)
//   mismatch_cnt  number of vectors where f_a != f_b (N+1 bits, never wraps)
//   first_bad     first vector where f_a != f_b
//   first_bad_vld first_bad holds a captured vector
//   equal         meaningful while done; 1 when no mismatch was seen
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | out of reset, no sweep run yet
// RUN   | applying one vector per cycle and accumulating results
// DONE  | sweep finished, results held until the next start

module truth_table_sweeper #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] vec,
    output logic         f_a,
    output logic         f_b,
    output logic [N:0]   mismatch_cnt,
    output logic [N-1:0] first_bad,
    output logic         first_bad_vld,
    output logic         equal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] ALL_ONES = '1;

    state_t     state;
    logic [1:0] mode_q;
    logic       x;
    logic [N-2:0] rest;
    logic       mis;
    logic       stop_now;
    logic [N:0] cnt_next;

    assign x    = vec[N-1];
    assign rest = vec[N-2:0];

    // Two structurally different implementations per pair. Pairs 1 and 2 are
    // De Morgan rewrites and must agree everywhere; pairs 0 and 3 are
    // deliberately non-equivalent so the checker itself can be seen to fire.
    always_comb begin
        f_a = 1'b0;
        f_b = 1'b0;
        case (mode_q)
            2'd0: begin
                f_a = ~x | (|rest);
                f_b = |vec;
            end
            2'd1: begin
                f_a = ~(&(~vec));
                f_b = |vec;
            end
            2'd2: begin
                f_a = ~(&vec);
                f_b = |(~vec);
            end
            default: begin
                f_a = ^vec;
                f_b = |vec;
            end
        endcase
    end

    assign mis      = f_a ^ f_b;
    assign cnt_next = mismatch_cnt + (N+1)'(mis);

`ifdef STOP_ON_MISMATCH_EN
    // Only the first mismatch can ever be seen: the sweep ends on it.
    assign stop_now = mis;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            vec           <= '0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
            equal         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        mode_q        <= mode;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        vec           <= '0;
                        mismatch_cnt  <= '0;
                        first_bad     <= '0;
                        first_bad_vld <= 1'b0;
                        equal         <= 1'b0;
                    end
                end
                RUN: begin
                    if (mis) begin
                        mismatch_cnt <= cnt_next;
                        if (!first_bad_vld) begin
                            first_bad     <= vec;
                            first_bad_vld <= 1'b1;
                        end
                    end
                    // vec is left in place on exit so DONE shows the last
                    // vector applied (all-ones, or the failing vector).
                    if (vec == ALL_ONES || stop_now) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        equal <= (cnt_next == '0);
                    end else begin
                        vec <= vec + N'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
